// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round helper functions and the core FSM state type.
package sha256_pkg;

  typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Element [7] is H0, so the packed vector matches the digest bit order directly.
  localparam logic [7:0][31:0] IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [7:0][31:0] IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One purely combinational SHA-256 compression round.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  input  logic [31:0] i_e,
  input  logic [31:0] i_f,
  input  logic [31:0] i_g,
  input  logic [31:0] i_h,
  input  logic [31:0] i_k,
  input  logic [31:0] i_w,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d,
  output logic [31:0] o_e,
  output logic [31:0] o_f,
  output logic [31:0] o_g,
  output logic [31:0] o_h
);

  logic [31:0] w_t1;
  logic [31:0] w_t2;

  // Temporaries T1/T2, all sums wrap mod 2^32.
  always_comb begin
    w_t1 = i_h + big_sigma1(i_e) + ch(i_e, i_f, i_g) + i_k + i_w;
    w_t2 = big_sigma0(i_a) + maj(i_a, i_b, i_c);
  end

  assign o_a = w_t1 + w_t2;
  assign o_b = i_a;
  assign o_c = i_b;
  assign o_d = i_c;
  assign o_e = i_d + w_t1;
  assign o_f = i_e;
  assign o_g = i_f;
  assign o_h = i_g;

endmodule

// File: rtl/sha256_multiblock_core.sv
// Iterative SHA-256/224 compression core with chaining state and RPC rounds per clock.
module sha256_multiblock_core
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter int unsigned SUPPORT_224      = 1
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_start,
  input  logic         i_first_block,
  input  logic         i_mode_224,
  input  logic [511:0] i_block_in,
  output logic         o_ready,
  output logic         o_hash_valid,
  output logic [255:0] o_hash_out
);

  localparam int         RPC      = int'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] LAST_CNT = 6'(64 - RPC);

  state_e           r_state;
  state_e           w_state_next;
  logic [5:0]       r_cnt;
  logic [7:0][31:0] r_h;
  logic [7:0][31:0] r_work;
  logic [31:0]      r_w [16];
  logic             r_mode;
  logic             r_hash_valid;
  logic [255:0]     r_hash_out;

  logic             w_mode_in;
  logic [7:0][31:0] w_h_start;
  logic [7:0][31:0] w_h_sum;
  logic [7:0][31:0] w_work_next;
  logic [31:0]      w_w_ext [16+RPC];

  assign w_mode_in = (SUPPORT_224 != 0) && i_mode_224;
  assign w_h_start = i_first_block ? (w_mode_in ? IV_224 : IV_256) : r_h;

  // Chain of RPC rounds; round i of this cycle uses K[t+i] and window word i.
  for (genvar i = 0; i < RPC; i++) begin : g_rnd
    logic [7:0][31:0] w_in;
    logic [7:0][31:0] w_out;
    if (i == 0) begin : g_head
      assign w_in = r_work;
    end else begin : g_tail
      assign w_in = g_rnd[i-1].w_out;
    end
    sha256_round u_round (
      .i_a (w_in[7]),
      .i_b (w_in[6]),
      .i_c (w_in[5]),
      .i_d (w_in[4]),
      .i_e (w_in[3]),
      .i_f (w_in[2]),
      .i_g (w_in[1]),
      .i_h (w_in[0]),
      .i_k (K[r_cnt + 6'(i)]),
      .i_w (r_w[i]),
      .o_a (w_out[7]),
      .o_b (w_out[6]),
      .o_c (w_out[5]),
      .o_d (w_out[4]),
      .o_e (w_out[3]),
      .o_f (w_out[2]),
      .o_g (w_out[1]),
      .o_h (w_out[0])
    );
  end
  assign w_work_next = g_rnd[RPC-1].w_out;

  // Extend the 16-word window by RPC new schedule words; later words may use earlier new ones.
  always_comb begin
    for (int i = 0; i < 16; i++) w_w_ext[i] = r_w[i];
    for (int j = 0; j < RPC; j++) begin
      w_w_ext[16+j] = small_sigma1(w_w_ext[14+j]) + w_w_ext[9+j]
                    + small_sigma0(w_w_ext[1+j]) + w_w_ext[j];
    end
  end

  // Feed-forward sum of chaining state and working variables.
  always_comb begin
    for (int i = 0; i < 8; i++) w_h_sum[i] = r_h[i] + r_work[i];
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StRound;
      StRound: if (r_cnt == LAST_CNT) w_state_next = StFinal;
      StFinal: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= StIdle;
    else            r_state <= w_state_next;
  end

  // Datapath: block capture, round iteration and digest update.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt        <= '0;
      r_h          <= IV_256;
      r_work       <= '0;
      r_mode       <= 1'b0;
      r_hash_valid <= 1'b0;
      r_hash_out   <= '0;
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
    end else begin
      r_hash_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            for (int i = 0; i < 16; i++) r_w[i] <= i_block_in[511-32*i -: 32];
            r_h    <= w_h_start;
            r_work <= w_h_start;
            r_cnt  <= '0;
            if (i_first_block) r_mode <= w_mode_in;
          end
        end
        StRound: begin
          for (int i = 0; i < 16; i++) r_w[i] <= w_w_ext[i+RPC];
          r_work <= w_work_next;
          r_cnt  <= r_cnt + 6'(RPC);
        end
        StFinal: begin
          r_h          <= w_h_sum;
          r_hash_valid <= 1'b1;
          // SHA-224 truncates to H0..H6; H7 is still kept for chaining.
          r_hash_out   <= r_mode ? {w_h_sum[7:1], 32'h0} : w_h_sum;
        end
        default: ;
      endcase
    end
  end

  assign o_ready      = (r_state == StIdle);
  assign o_hash_valid = r_hash_valid;
  assign o_hash_out   = r_hash_out;

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// Randomized self-checking bench for sha256_multiblock_core at RPC 1, 2, 4 (plus a 256-only build).
module tb_sha256_multiblock_core;

  localparam int NDUT = 4;

  localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
    32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] DIG_ABC   =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DIG_TWO   =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] DIG_224   =
    256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         st   [NDUT];
  logic         fb   [NDUT];
  logic         m224 [NDUT];
  logic [511:0] blk  [NDUT];
  logic         rdy  [NDUT];
  logic         hv   [NDUT];
  logic [255:0] ho   [NDUT];

  int total = 0;
  int bad   = 0;

  // Reference model state per DUT.
  logic [255:0] mh    [NDUT];
  logic         mmode [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned R = (g == 3) ? 4 : (1 << g);
    localparam int unsigned S = (g == 3) ? 0 : 1;
    sha256_multiblock_core #(
      .ROUNDS_PER_CYCLE (R),
      .SUPPORT_224      (S)
    ) u_dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_start       (st[g]),
      .i_first_block (fb[g]),
      .i_mode_224    (m224[g]),
      .i_block_in    (blk[g]),
      .o_ready       (rdy[g]),
      .o_hash_valid  (hv[g]),
      .o_hash_out    (ho[g])
    );
  end

  function automatic int rpc_of(input int d);
    return (d == 3) ? 4 : (1 << d);
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word schedule, then 64 rounds, then feed-forward.
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] hout;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return hout;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      mh[i]    = IV256;
      mmode[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input logic [511:0] b, input bit f, input bit m,
                            output logic [255:0] exp_dig);
    logic [255:0] h;
    if (f) begin
      mmode[d] = m && (d != 3);
      h = mmode[d] ? IV224 : IV256;
    end else begin
      h = mh[d];
    end
    mh[d]   = ref_compress(h, b);
    exp_dig = mmode[d] ? {mh[d][255:32], 32'h0} : mh[d];
  endtask

  // Present a block once ready; returns #1 after the accepting edge with inputs scrambled.
  task automatic issue(input int d, input logic [511:0] b, input bit f, input bit m);
    int n = 0;
    while (rdy[d] !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL ready_timeout dut%0d: ready=%b want 1", d, rdy[d]);
    end
    st[d]   = 1'b1;
    blk[d]  = b;
    fb[d]   = f;
    m224[d] = m;
    @(posedge clk);
    #1;
    st[d]   = 1'b0;
    blk[d]  = rand512();
    fb[d]   = 1'($urandom_range(0, 1));
    m224[d] = 1'($urandom_range(0, 1));
  endtask

  // Count edges until hash_valid (bounded); the latency check catches a timeout.
  task automatic wait_valid(input int d, output int cyc, output logic [255:0] dig);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (hv[d] !== 1'b1 && cyc < 200);
    dig = ho[d];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      st[i] = 1'b0; fb[i] = 1'b0; m224[i] = 1'b0; blk[i] = '0;
    end
    #12;
    for (int i = 0; i < NDUT; i++) begin
      total++;
      if (rdy[i] !== 1'b1) begin bad++; $display("FAIL reset_ready dut%0d: %b want 1", i, rdy[i]); end
      total++;
      if (hv[i] !== 1'b0) begin bad++; $display("FAIL reset_valid dut%0d: %b want 0", i, hv[i]); end
      total++;
      if (ho[i] !== '0) begin bad++; $display("FAIL reset_hash dut%0d: %h want 0", i, ho[i]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_abc(input int d);
    int cyc;
    logic [255:0] dig, exp_dig;
    int lat = 64 / rpc_of(d) + 1;
    model_step(d, BLK_ABC, 1'b1, 1'b0, exp_dig);
    issue(d, BLK_ABC, 1'b1, 1'b0);
    wait_valid(d, cyc, dig);
    total++;
    if (cyc !== lat) begin bad++; $display("FAIL abc_latency dut%0d: %0d want %0d", d, cyc, lat); end
    total++;
    if (dig !== DIG_ABC) begin bad++; $display("FAIL abc_digest dut%0d: %h want %h", d, dig, DIG_ABC); end
    total++;
    if (dig !== exp_dig) begin bad++; $display("FAIL abc_model dut%0d: %h want %h", d, dig, exp_dig); end
    @(posedge clk);
    #1;
    total++;
    if (hv[d] !== 1'b0) begin bad++; $display("FAIL abc_pulse_width dut%0d: %b want 0", d, hv[d]); end
    total++;
    if (ho[d] !== DIG_ABC) begin bad++; $display("FAIL abc_hold dut%0d: %h want %h", d, ho[d], DIG_ABC); end
  endtask

  task automatic test_empty(input int d);
    int cyc;
    logic [255:0] dig, exp_dig;
    model_step(d, BLK_EMPTY, 1'b1, 1'b0, exp_dig);
    issue(d, BLK_EMPTY, 1'b1, 1'b0);
    wait_valid(d, cyc, dig);
    total++;
    if (dig !== DIG_EMPTY) begin
      bad++; $display("FAIL empty_digest dut%0d: %h want %h", d, dig, DIG_EMPTY);
    end
    total++;
    if (dig !== exp_dig) begin bad++; $display("FAIL empty_model dut%0d: %h want %h", d, dig, exp_dig); end
  endtask

  task automatic test_back_to_back(input int d);
    int cyc;
    logic [255:0] dig, exp_dig;
    int lat = 64 / rpc_of(d) + 1;
    model_step(d, BLK_TWO1, 1'b1, 1'b0, exp_dig);
    issue(d, BLK_TWO1, 1'b1, 1'b0);
    wait_valid(d, cyc, dig);
    total++;
    if (dig !== exp_dig) begin bad++; $display("FAIL two_blk1 dut%0d: %h want %h", d, dig, exp_dig); end
    total++;
    if (rdy[d] !== 1'b1) begin bad++; $display("FAIL two_ready_in_valid dut%0d: %b want 1", d, rdy[d]); end
    // Second start goes in during the hash_valid cycle.
    model_step(d, BLK_TWO2, 1'b0, 1'b0, exp_dig);
    issue(d, BLK_TWO2, 1'b0, 1'b0);
    wait_valid(d, cyc, dig);
    total++;
    if (cyc !== lat) begin bad++; $display("FAIL two_latency dut%0d: %0d want %0d", d, cyc, lat); end
    total++;
    if (dig !== DIG_TWO) begin bad++; $display("FAIL two_digest dut%0d: %h want %h", d, dig, DIG_TWO); end
    total++;
    if (dig !== exp_dig) begin bad++; $display("FAIL two_model dut%0d: %h want %h", d, dig, exp_dig); end
  endtask

  task automatic test_224(input int d);
    int cyc;
    logic [255:0] dig, exp_dig;
    model_step(d, BLK_ABC, 1'b1, 1'b1, exp_dig);
    issue(d, BLK_ABC, 1'b1, 1'b1);
    wait_valid(d, cyc, dig);
    total++;
    if (dig !== DIG_224) begin bad++; $display("FAIL sha224_digest dut%0d: %h want %h", d, dig, DIG_224); end
    total++;
    if (dig !== exp_dig) begin bad++; $display("FAIL sha224_model dut%0d: %h want %h", d, dig, exp_dig); end
  endtask

  task automatic test_busy(input int d);
    int cyc;
    bit early_hv = 1'b0;
    logic [255:0] dig, exp_dig;
    int lat = 64 / rpc_of(d) + 1;
    model_step(d, BLK_ABC, 1'b1, 1'b0, exp_dig);
    issue(d, BLK_ABC, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (hv[d] === 1'b1) early_hv = 1'b1;
      if (k >= 2 && k <= 4) begin
        st[d] = 1'b1; blk[d] = rand512(); fb[d] = 1'b1; m224[d] = 1'b1;
      end else begin
        st[d] = 1'b0;
      end
    end
    wait_valid(d, cyc, dig);
    total++;
    if (early_hv) begin bad++; $display("FAIL busy_early_valid dut%0d: got 1 want 0", d); end
    total++;
    if (cyc + 6 !== lat) begin bad++; $display("FAIL busy_latency dut%0d: %0d want %0d", d, cyc + 6, lat); end
    total++;
    if (dig !== DIG_ABC) begin bad++; $display("FAIL busy_digest dut%0d: %h want %h", d, dig, DIG_ABC); end
    total++;
    if (dig !== exp_dig) begin bad++; $display("FAIL busy_model dut%0d: %h want %h", d, dig, exp_dig); end
  endtask

  task automatic test_random(input int d, input int nblk);
    int cyc;
    logic [255:0] dig, exp_dig;
    logic [511:0] b;
    bit f, m;
    int lat = 64 / rpc_of(d) + 1;
    for (int n = 0; n < nblk; n++) begin
      b = rand512();
      f = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      model_step(d, b, f, m, exp_dig);
      issue(d, b, f, m);
      wait_valid(d, cyc, dig);
      total++;
      if (cyc !== lat) begin bad++; $display("FAIL rand_latency dut%0d #%0d: %0d want %0d", d, n, cyc, lat); end
      total++;
      if (dig !== exp_dig) begin bad++; $display("FAIL rand_digest dut%0d #%0d: %h want %h", d, n, dig, exp_dig); end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_abort(input int d);
    int cyc;
    bit saw_hv = 1'b0;
    logic [255:0] dig, exp_dig;
    int lat = 64 / rpc_of(d) + 1;
    issue(d, BLK_ABC, 1'b1, 1'b0);
    repeat (30 / rpc_of(d)) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (rdy[d] !== 1'b1) begin bad++; $display("FAIL abort_ready dut%0d: %b want 1", d, rdy[d]); end
    total++;
    if (hv[d] !== 1'b0) begin bad++; $display("FAIL abort_valid dut%0d: %b want 0", d, hv[d]); end
    total++;
    if (ho[d] !== '0) begin bad++; $display("FAIL abort_hash dut%0d: %h want 0", d, ho[d]); end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (hv[d] === 1'b1) saw_hv = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (70) begin
      @(posedge clk);
      #1;
      if (hv[d] === 1'b1) saw_hv = 1'b1;
    end
    total++;
    if (saw_hv) begin bad++; $display("FAIL abort_no_valid dut%0d: got 1 want 0", d); end
    model_step(d, BLK_ABC, 1'b1, 1'b0, exp_dig);
    issue(d, BLK_ABC, 1'b1, 1'b0);
    wait_valid(d, cyc, dig);
    total++;
    if (cyc !== lat) begin bad++; $display("FAIL abort_rerun_latency dut%0d: %0d want %0d", d, cyc, lat); end
    total++;
    if (dig !== DIG_ABC) begin bad++; $display("FAIL abort_rerun_digest dut%0d: %h want %h", d, dig, DIG_ABC); end
  endtask

  // DUT 3 is built without SHA-224 support and has been idle since the last reset.
  task automatic test_no224();
    int cyc;
    logic [255:0] dig, exp_dig;
    model_step(3, BLK_ABC, 1'b0, 1'b1, exp_dig);
    issue(3, BLK_ABC, 1'b0, 1'b1);
    wait_valid(3, cyc, dig);
    total++;
    if (dig !== DIG_ABC) begin bad++; $display("FAIL chain_after_reset: %h want %h", dig, DIG_ABC); end
    model_step(3, BLK_ABC, 1'b1, 1'b1, exp_dig);
    issue(3, BLK_ABC, 1'b1, 1'b1);
    wait_valid(3, cyc, dig);
    total++;
    if (cyc !== 17) begin bad++; $display("FAIL no224_latency: %0d want 17", cyc); end
    total++;
    if (dig !== DIG_ABC) begin bad++; $display("FAIL no224_digest: %h want %h", dig, DIG_ABC); end
    total++;
    if (dig !== exp_dig) begin bad++; $display("FAIL no224_model: %h want %h", dig, exp_dig); end
    test_random(3, 4);
  endtask

  initial begin
    test_reset();
    for (int d = 0; d < 3; d++) begin
      test_abc(d);
      test_empty(d);
      test_back_to_back(d);
      test_224(d);
      test_busy(d);
      test_random(d, 6);
    end
    for (int d = 0; d < 3; d++) test_abort(d);
    test_no224();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
